// File: rtl/mem_bus_master.sv
// Request sequencer for the 256x16 synchronous RAM stage: turns one load/store request
// at a time into MREAD/MWRITE bus cycles and returns a single response per request.
module mem_bus_master #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 16,
   parameter int RD_WAIT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MWRITE = 2'b01;
   localparam logic [1:0] MREAD  = 2'b10;
   localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_RSP
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic [1:0]        mem_cmd_q, mem_cmd_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;

   // Both channels: a transfer happens on a rising edge where valid and ready are both high;
   // the sender holds valid and its payload unchanged until that edge.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      write_d      = write_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      mem_cmd_d    = MNONE;
      mem_addr_d   = mem_addr_q;
      write_data_d = write_data_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               write_d = req_write;
               err_d   = req_addr[ADDR_W-1];
               if (req_addr[ADDR_W-1]) begin
                  state_d = S_RSP;
               end else if (req_write) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD_ISSUE;
               end
            end
         end
         S_WR: begin
            state_d = S_RSP;
         end
         S_RD_ISSUE: begin
            cnt_d   = CNT_W'(RD_WAIT - 1);
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RSP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RSP: begin
            if (rsp_valid_q && rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Bus and response registers trail the state by one cycle, so MREAD is still on the
      // bus at the edge where read_data is captured into the response.
      if (state_q == S_WR) begin
         mem_cmd_d    = MWRITE;
         mem_addr_d   = addr_q;
         write_data_d = wdata_q;
      end
      if (state_q == S_RD_ISSUE || state_q == S_RD_WAIT) begin
         mem_cmd_d  = MREAD;
         mem_addr_d = addr_q;
      end
      if (state_q == S_RSP) begin
         if (!rsp_valid_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_q;
            rsp_rdata_d = (!err_q && !write_q) ? read_data : '0;
         end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
         end
      end

      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         mem_cmd_q    <= MNONE;
         mem_addr_q   <= '0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         write_q      <= write_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         mem_cmd_q    <= mem_cmd_d;
         mem_addr_q   <= mem_addr_d;
         write_data_q <= write_data_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;
   assign mem_cmd    = mem_cmd_q;
   assign mem_addr   = mem_addr_q;
   assign write_data = write_data_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (RD_WAIT=1 and RD_WAIT=3), each with its own RAM
// model; vector table, reset corner cases, and randomized traffic against a memory model.
module tb_mem_bus_master;

   localparam int RDW1 = 1;
   localparam int RDW3 = 3;

   logic clk;
   logic reset_n;
   logic preload;
   logic sel3;

   logic        req_valid1, req_write1, rsp_ready1;
   logic [8:0]  req_addr1;
   logic [15:0] req_wdata1;
   logic        req_ready1, rsp_valid1, rsp_err1;
   logic [15:0] rsp_rdata1, write_data1, read_data1;
   logic [1:0]  mem_cmd1;
   logic [8:0]  mem_addr1;

   logic        req_valid3, req_write3, rsp_ready3;
   logic [8:0]  req_addr3;
   logic [15:0] req_wdata3;
   logic        req_ready3, rsp_valid3, rsp_err3;
   logic [15:0] rsp_rdata3, write_data3, read_data3;
   logic [1:0]  mem_cmd3;
   logic [8:0]  mem_addr3;

   int n_checks;
   int n_fail;

   mem_bus_master #(.ADDR_W(9), .DATA_W(16), .RD_WAIT(RDW1)) u_dut1 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
      .req_addr(req_addr1), .req_wdata(req_wdata1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
      .mem_cmd(mem_cmd1), .mem_addr(mem_addr1), .write_data(write_data1), .read_data(read_data1)
   );

   mem_bus_master #(.ADDR_W(9), .DATA_W(16), .RD_WAIT(RDW3)) u_dut3 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
      .req_addr(req_addr3), .req_wdata(req_wdata3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
      .mem_cmd(mem_cmd3), .mem_addr(mem_addr3), .write_data(write_data3), .read_data(read_data3)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models: registered read port, data valid only the cycle after an MREAD is seen
   function automatic logic [15:0] init_word(input int i);
      return 16'(i * 257) ^ 16'h5A5A;
   endfunction

   logic [15:0] ram1 [512];
   logic [15:0] ram3 [512];
   logic [15:0] rd1_q, rd3_q;
   logic        rd1_v, rd3_v;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 512; i++) begin
            ram1[i] <= init_word(i);
            ram3[i] <= init_word(i);
         end
         ram3[9'h0FF] <= 16'h1234;
      end else begin
         if (mem_cmd1 == 2'b01) ram1[mem_addr1] <= write_data1;
         if (mem_cmd3 == 2'b01) ram3[mem_addr3] <= write_data3;
      end
      rd1_v <= (mem_cmd1 == 2'b10);
      rd3_v <= (mem_cmd3 == 2'b10);
      rd1_q <= ram1[mem_addr1];
      rd3_q <= ram3[mem_addr3];
   end

   assign read_data1 = rd1_v ? rd1_q : 16'hDEAD;
   assign read_data3 = rd3_v ? rd3_q : 16'hDEAD;

   // observation of whichever instance is selected
   wire        o_req_ready  = sel3 ? req_ready3  : req_ready1;
   wire        o_rsp_valid  = sel3 ? rsp_valid3  : rsp_valid1;
   wire [15:0] o_rsp_rdata  = sel3 ? rsp_rdata3  : rsp_rdata1;
   wire        o_rsp_err    = sel3 ? rsp_err3    : rsp_err1;
   wire [1:0]  o_mem_cmd    = sel3 ? mem_cmd3    : mem_cmd1;
   wire [8:0]  o_mem_addr   = sel3 ? mem_addr3   : mem_addr1;
   wire [15:0] o_write_data = sel3 ? write_data3 : write_data1;

   // reference memory for the RD_WAIT=1 instance
   logic [15:0] ref_mem [512];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input logic v, input logic w, input logic [8:0] a,
                        input logic [15:0] d, input logic rr);
      if (sel3) begin
         req_valid3 = v; req_write3 = w; req_addr3 = a; req_wdata3 = d; rsp_ready3 = rr;
      end else begin
         req_valid1 = v; req_write1 = w; req_addr1 = a; req_wdata1 = d; rsp_ready1 = rr;
      end
   endtask

   task automatic txn(input logic w, input logic [8:0] a, input logic [15:0] d, input int hold,
                      output logic found, output int lat, output logic [15:0] rd, output logic er,
                      output int nwr, output int nrd, output logic [8:0] wa, output logic [15:0] wd,
                      output logic rdy_ok, output logic hold_ok, output logic post_ok);
      found = 1'b0; lat = 0; rd = '0; er = 1'b0; nwr = 0; nrd = 0;
      wa = '0; wd = '0; hold_ok = 1'b1; post_ok = 1'b0;
      @(negedge clk);
      rdy_ok = o_req_ready;
      drive(1'b1, w, a, d, 1'b0);
      @(posedge clk);
      for (int k = 0; k <= 40; k++) begin
         if (!found) begin
            @(negedge clk);
            if (k == 0) drive(1'b0, 1'b0, '0, '0, 1'b0);
            if (o_mem_cmd == 2'b01) begin
               nwr++; wa = o_mem_addr; wd = o_write_data;
            end
            if (o_mem_cmd == 2'b10) nrd++;
            if (o_rsp_valid) begin
               found = 1'b1; lat = k; rd = o_rsp_rdata; er = o_rsp_err;
            end
         end
      end
      if (found) begin
         for (int h = 0; h < hold; h++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 16'($urandom), 1'b0);
            @(negedge clk);
            if (!o_rsp_valid || o_rsp_rdata !== rd || o_rsp_err !== er || o_req_ready ||
                o_mem_cmd != 2'b00) hold_ok = 1'b0;
         end
         drive(1'b0, 1'b0, '0, '0, 1'b1);
         @(negedge clk);
         drive(1'b0, 1'b0, '0, '0, 1'b0);
         post_ok = !o_rsp_valid && o_req_ready && (o_mem_cmd == 2'b00);
      end
   endtask

   task automatic apply(input string tag, input logic w, input logic [8:0] a, input logic [15:0] d,
                        input int hold, input logic e_err, input logic [15:0] e_rd,
                        input int e_lat, input int e_nwr, input int e_nrd);
      logic found, er, rdy_ok, hold_ok, post_ok;
      int lat, nwr, nrd;
      logic [15:0] rd, wd;
      logic [8:0] wa;
      txn(w, a, d, hold, found, lat, rd, er, nwr, nrd, wa, wd, rdy_ok, hold_ok, post_ok);
      chk({tag, " req_ready"}, 32'(rdy_ok), 32'd1);
      chk({tag, " rsp_seen"}, 32'(found), 32'd1);
      if (found) begin
         chk({tag, " latency"}, 32'(lat), 32'(e_lat));
         chk({tag, " rsp_err"}, 32'(er), 32'(e_err));
         chk({tag, " rsp_rdata"}, 32'(rd), 32'(e_rd));
         chk({tag, " mwrite_cycles"}, 32'(nwr), 32'(e_nwr));
         chk({tag, " mread_cycles"}, 32'(nrd), 32'(e_nrd));
         if (e_nwr == 1) begin
            chk({tag, " bus_addr"}, 32'(wa), 32'(a));
            chk({tag, " bus_data"}, 32'(wd), 32'(d));
         end
         if (hold > 0) chk({tag, " hold_stable"}, 32'(hold_ok), 32'd1);
         chk({tag, " post_handshake"}, 32'(post_ok), 32'd1);
      end
   endtask

   typedef struct {
      int          sel;
      logic        w;
      logic [8:0]  a;
      logic [15:0] d;
      int          hold;
      logic        err;
      logic [15:0] rd;
      int          lat;
      int          nwr;
      int          nrd;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int   seen;
      n_checks = 0;
      n_fail   = 0;
      sel3     = 1'b0;
      preload  = 1'b1;
      reset_n  = 1'b0;
      req_valid1 = 0; req_write1 = 0; req_addr1 = '0; req_wdata1 = '0; rsp_ready1 = 0;
      req_valid3 = 0; req_write3 = 0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 0;
      for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);

      //       sel w     addr    data      hold err  rdata    lat nwr nrd
      vecs[0] = '{1, 1'b1, 9'h005, 16'hABCD, 0, 1'b0, 16'h0000, 2, 1, 0};
      vecs[1] = '{1, 1'b0, 9'h005, 16'h0000, 0, 1'b0, 16'hABCD, 3, 0, 2};
      vecs[2] = '{1, 1'b0, 9'h140, 16'h0000, 0, 1'b1, 16'h0000, 1, 0, 0};
      vecs[3] = '{1, 1'b1, 9'h140, 16'h1111, 2, 1'b1, 16'h0000, 1, 0, 0};
      vecs[4] = '{1, 1'b0, 9'h005, 16'h0000, 5, 1'b0, 16'hABCD, 3, 0, 2};
      vecs[5] = '{1, 1'b1, 9'h0FF, 16'h7777, 1, 1'b0, 16'h0000, 2, 1, 0};
      vecs[6] = '{1, 1'b0, 9'h0FF, 16'h0000, 0, 1'b0, 16'h7777, 3, 0, 2};
      vecs[7] = '{3, 1'b0, 9'h0FF, 16'h0000, 0, 1'b0, 16'h1234, 5, 0, 4};
      vecs[8] = '{3, 1'b1, 9'h0FE, 16'hBEEF, 3, 1'b0, 16'h0000, 2, 1, 0};
      vecs[9] = '{3, 1'b0, 9'h0FE, 16'h0000, 0, 1'b0, 16'hBEEF, 5, 0, 4};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset req_ready", 32'(req_ready1), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid1), 32'd0);
      chk("reset rsp_rdata", 32'(rsp_rdata1), 32'd0);
      chk("reset rsp_err", 32'(rsp_err1), 32'd0);
      chk("reset mem_cmd", 32'(mem_cmd1), 32'd0);
      chk("reset mem_addr", 32'(mem_addr1), 32'd0);
      chk("reset write_data", 32'(write_data1), 32'd0);
      chk("reset3 req_ready", 32'(req_ready3), 32'd1);
      preload = 1'b0;
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         sel3 = (vecs[i].sel == 3);
         apply($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].hold,
               vecs[i].err, vecs[i].rd, vecs[i].lat, vecs[i].nwr, vecs[i].nrd);
         if (!sel3 && vecs[i].w && !vecs[i].a[8]) ref_mem[vecs[i].a] = vecs[i].d;
      end
      sel3 = 1'b0;

      // reset asserted while a load sits in its read-wait cycle
      @(negedge clk);
      req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 9'h010; rsp_ready1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid1 = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midreset mem_cmd", 32'(mem_cmd1), 32'd0);
      chk("midreset rsp_valid", 32'(rsp_valid1), 32'd0);
      chk("midreset req_ready", 32'(req_ready1), 32'd1);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      rsp_ready1 = 1'b1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rsp_valid1 || mem_cmd1 != 2'b00) seen++;
      end
      rsp_ready1 = 1'b0;
      chk("midreset no_response", 32'(seen), 32'd0);
      chk("midreset idle_ready", 32'(req_ready1), 32'd1);

      // randomized traffic against the reference memory
      for (int n = 0; n < 60; n++) begin
         logic        w, err;
         logic [8:0]  a;
         logic [15:0] d, e_rd;
         int          hold;
         w    = 1'($urandom_range(0, 1));
         a    = {($urandom_range(0, 7) == 0), 8'($urandom_range(0, 15))};
         d    = 16'($urandom);
         hold = $urandom_range(0, 3);
         err  = a[8];
         e_rd = (!err && !w) ? ref_mem[a] : 16'h0000;
         apply($sformatf("rnd%0d", n), w, a, d, hold, err, e_rd,
               err ? 1 : (w ? 2 : 2 + RDW1),
               (!err && w) ? 1 : 0,
               (!err && !w) ? RDW1 + 1 : 0);
         if (!err && w) ref_mem[a] = d;
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
